// File: rtl/tx_repeater_fifo.sv
// UART loopback repeater: each received word plus INC is buffered in a FIFO and paced out to
// the transmitter. Define TX_REPEATER_STATS_EN to add the rx_cnt/tx_cnt statistics ports.
module tx_repeater_fifo #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned INC          = 1,
   parameter int unsigned GAP_CYCLES   = 0,
   parameter int unsigned DONE_TIMEOUT = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   Rx_valid,
   input  logic [DATA_W-1:0]      Rx_data,
   output logic                   iTx_DV,
   output logic [DATA_W-1:0]      tx_data,
   input  logic                   o_Tx_Done,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow,
   output logic                   tx_timeout
`ifdef TX_REPEATER_STATS_EN
   ,
   output logic [15:0]            rx_cnt,
   output logic [15:0]            tx_cnt
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
   localparam logic [DATA_W-1:0] INC_C    = DATA_W'(INC);
   // Counters hold "cycles remaining after this one", so they load N-1 and expire at zero.
   localparam logic [TW-1:0]     TMO_LOAD = TW'(DONE_TIMEOUT - 1);
   localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic                dv_q, dv_d;
   logic [DATA_W-1:0]   txd_q, txd_d;
   logic                ovf_q, ovf_d;
   logic                to_q, to_d;
   logic                push, pop;

   // The FIFO pops during the ISSUE clock, which frees a slot for a same-clock push when full.
   always_comb begin
      pop      = (state_q == S_ISSUE);
      push     = Rx_valid && ((count_q < DEPTH_C) || pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ovf_d    = ovf_q | (Rx_valid & ~push);
   end

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      gap_d   = gap_q;
      to_d    = to_q;
      txd_d   = txd_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_ISSUE;
               txd_d   = mem_q[rd_ptr_q];
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            tmo_d   = TMO_LOAD;
         end
         S_WAIT: begin
            if (o_Tx_Done) begin
               if (GAP_CYCLES != 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (tmo_q == '0) begin
               // Word is given up as lost; no retry.
               to_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      dv_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tmo_q    <= '0;
         gap_q    <= '0;
         dv_q     <= 1'b0;
         txd_q    <= '0;
         ovf_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tmo_q    <= tmo_d;
         gap_q    <= gap_d;
         dv_q     <= dv_d;
         txd_q    <= txd_d;
         ovf_q    <= ovf_d;
         to_q     <= to_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= Rx_data + INC_C;
   end

   assign iTx_DV     = dv_q;
   assign tx_data    = txd_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;
   assign tx_timeout = to_q;

`ifdef TX_REPEATER_STATS_EN
   logic [15:0] rx_cnt_q, tx_cnt_q;

   // Counts every received pulse, including words dropped on overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt_q <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (Rx_valid) rx_cnt_q <= rx_cnt_q + 16'd1;
         if (dv_q)     tx_cnt_q <= tx_cnt_q + 16'd1;
      end
   end

   assign rx_cnt = rx_cnt_q;
   assign tx_cnt = tx_cnt_q;
`endif

endmodule

// File: tb/tb_tx_repeater_fifo.sv
// Two repeater configurations share one stimulus stream; a queue/timestamp model is compared
// every cycle, and directed literal checks pin latency, wrap, overflow, timeout, gap and reset.
`timescale 1ns/1ps
module tb_tx_repeater_fifo;

   localparam int A_DEPTH = 4, A_INC = 1, A_GAP = 0, A_TO = 8;
   localparam int B_DEPTH = 8, B_INC = 5, B_GAP = 5, B_TO = 20;

   logic       clk = 1'b0, rst = 1'b1, rx_v = 1'b0, done = 1'b0;
   logic [7:0] rx_d = 8'h00;
   logic       dv_a, dv_b, ovf_a, ovf_b, to_a, to_b;
   logic [7:0] txd_a, txd_b;
   logic [2:0] cnt_a;
   logic [3:0] cnt_b;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

`ifdef TX_REPEATER_STATS_EN
   logic [15:0] rxc_a, txc_a, rxc_b, txc_b;
`endif

   tx_repeater_fifo #(.DATA_W(8), .DEPTH(A_DEPTH), .INC(A_INC), .GAP_CYCLES(A_GAP),
                      .DONE_TIMEOUT(A_TO)) dut_a (
      .clk(clk), .rst(rst), .Rx_valid(rx_v), .Rx_data(rx_d), .iTx_DV(dv_a), .tx_data(txd_a),
      .o_Tx_Done(done), .fifo_count(cnt_a), .overflow(ovf_a), .tx_timeout(to_a)
`ifdef TX_REPEATER_STATS_EN
      , .rx_cnt(rxc_a), .tx_cnt(txc_a)
`endif
   );

   tx_repeater_fifo #(.DATA_W(8), .DEPTH(B_DEPTH), .INC(B_INC), .GAP_CYCLES(B_GAP),
                      .DONE_TIMEOUT(B_TO)) dut_b (
      .clk(clk), .rst(rst), .Rx_valid(rx_v), .Rx_data(rx_d), .iTx_DV(dv_b), .tx_data(txd_b),
      .o_Tx_Done(done), .fifo_count(cnt_b), .overflow(ovf_b), .tx_timeout(to_b)
`ifdef TX_REPEATER_STATS_EN
      , .rx_cnt(rxc_b), .tx_cnt(txc_b)
`endif
   );

   // ---------------- model: word queue plus timestamps of the transmit window ----------------
   logic [7:0]  mq [2][64];
   int          hd [2], tl [2];
   bit          m_dv [2], m_ovf [2], m_to [2], outst [2];
   logic [7:0]  m_txd [2];
   longint      cyc = 0;
   longint      idle_after [2], wfirst [2], wlast [2];
   logic [15:0] m_rx, m_tx [2];
   bit          armed = 1'b0;
   logic [7:0]  seen_a [$];

   task automatic step(input int k);
      int dep, inc, gap, tmo, sz;
      bit pop, nd;
      dep = (k == 0) ? A_DEPTH : B_DEPTH;
      inc = (k == 0) ? A_INC   : B_INC;
      gap = (k == 0) ? A_GAP   : B_GAP;
      tmo = (k == 0) ? A_TO    : B_TO;
      sz  = tl[k] - hd[k];
      pop = m_dv[k];
      nd  = 1'b0;
      if (rst) begin
         hd[k] = 0; tl[k] = 0; outst[k] = 1'b0; idle_after[k] = cyc;
         m_dv[k] = 1'b0; m_txd[k] = 8'h00; m_ovf[k] = 1'b0; m_to[k] = 1'b0; m_tx[k] = '0;
         if (k == 0) m_rx = '0;
         return;
      end
      if (pop) m_tx[k] = m_tx[k] + 16'd1;
      if (k == 0 && rx_v) m_rx = m_rx + 16'd1;
      // An issued word is answered by a done in clocks issue+2 .. issue+1+timeout.
      if (outst[k]) begin
         if (cyc >= wfirst[k]) begin
            if (done) begin
               outst[k] = 1'b0; idle_after[k] = cyc + gap;
            end else if (cyc == wlast[k]) begin
               m_to[k] = 1'b1; outst[k] = 1'b0; idle_after[k] = cyc;
            end
         end
      end else if (cyc > idle_after[k] && sz > 0) begin
         nd = 1'b1; m_txd[k] = mq[k][hd[k] % 64]; outst[k] = 1'b1;
         wfirst[k] = cyc + 2; wlast[k] = cyc + 1 + tmo;
      end
      if (rx_v) begin
         if (sz < dep || pop) begin
            mq[k][tl[k] % 64] = rx_d + 8'(inc);
            tl[k]++;
         end else begin
            m_ovf[k] = 1'b1;
         end
      end
      if (pop) hd[k]++;
      m_dv[k] = nd;
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) armed = 1'b1;
      for (int k = 0; k < 2; k++) step(k);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (armed) begin
         chk("m_dv_a",  32'(dv_a),  32'(m_dv[0]));
         chk("m_txd_a", 32'(txd_a), 32'(m_txd[0]));
         chk("m_cnt_a", 32'(cnt_a), 32'(tl[0] - hd[0]));
         chk("m_ovf_a", 32'(ovf_a), 32'(m_ovf[0]));
         chk("m_to_a",  32'(to_a),  32'(m_to[0]));
         chk("m_dv_b",  32'(dv_b),  32'(m_dv[1]));
         chk("m_txd_b", 32'(txd_b), 32'(m_txd[1]));
         chk("m_cnt_b", 32'(cnt_b), 32'(tl[1] - hd[1]));
         chk("m_ovf_b", 32'(ovf_b), 32'(m_ovf[1]));
         chk("m_to_b",  32'(to_b),  32'(m_to[1]));
`ifdef TX_REPEATER_STATS_EN
         chk("m_rxc_a", 32'(rxc_a), 32'(m_rx));
         chk("m_txc_a", 32'(txc_a), 32'(m_tx[0]));
         chk("m_txc_b", 32'(txc_b), 32'(m_tx[1]));
`endif
         if (dv_a) seen_a.push_back(txd_a);
      end
   end

   // ---------------- stimulus helpers (inputs change on the falling edge) ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic burst(input logic [7:0] base, input logic [7:0] stp, input int n);
      for (int i = 0; i < n; i++) begin
         rx_v = 1'b1;
         rx_d = base + 8'(i) * stp;
         @(negedge clk);
      end
      rx_v = 1'b0;
   endtask

   task automatic pulse_done(input int n);
      done = 1'b1;
      repeat (n) @(negedge clk);
      done = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen_a.delete();
   endtask

   task automatic expect_tx(input string nm, input logic [7:0] exp);
      int n = 0;
      while (seen_a.size() == 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (seen_a.size() == 0) chk(nm, 32'h100, {24'h0, exp});
      else                    chk(nm, {24'h0, seen_a.pop_front()}, {24'h0, exp});
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      chk("rst_dv",  32'(dv_a),  0);
      chk("rst_txd", 32'(txd_a), 0);
      chk("rst_cnt", 32'(cnt_a), 0);
      chk("rst_ovf", 32'(ovf_a), 0);
      chk("rst_to",  32'(to_a),  0);

      // single byte: issue two clocks after Rx_valid
      burst(8'h41, 8'h00, 1);
      chk("single_no_dv_yet", 32'(dv_a), 0);
      chk("single_cnt1",      32'(cnt_a), 1);
      tick(1);
      chk("single_dv_a",  32'(dv_a),  1);
      chk("single_txd_a", 32'(txd_a), 32'h42);
      chk("single_dv_b",  32'(dv_b),  1);
      chk("single_txd_b", 32'(txd_b), 32'h46);
      tick(1);
      chk("single_dv_low", 32'(dv_a), 0);
      chk("single_cnt0",   32'(cnt_a), 0);
      pulse_done(1);
      tick(1);

      // wrap and ordered burst
      burst(8'hFF, 8'h00, 1);
      chk("wrap_no_dv_yet", 32'(dv_a), 0);
      tick(1);
      chk("wrap_dv",  32'(dv_a),  1);
      chk("wrap_txd", 32'(txd_a), 32'h00);
      tick(1);
      pulse_done(1);
      seen_a.delete();
      burst(8'h10, 8'h10, 3);
      for (int i = 0; i < 3; i++) begin
         expect_tx("burst_order", 8'h11 + 8'(i) * 8'h10);
         pulse_done(2);
      end
      tick(3);
      chk("burst_drained", 32'(cnt_a), 0);
      chk("burst_no_extra", 32'(seen_a.size()), 0);

      // overflow: 1 issued + 4 buffered, 6th dropped
      do_reset();
      burst(8'h01, 8'h01, 6);
      chk("ovf_set_a",  32'(ovf_a), 1);
      chk("ovf_cnt_a",  32'(cnt_a), 4);
      chk("ovf_clr_b",  32'(ovf_b), 0);
      chk("ovf_cnt_b",  32'(cnt_b), 5);
      expect_tx("ovf_first", 8'h02);
      for (int i = 0; i < 4; i++) begin
         pulse_done(2);
         expect_tx("ovf_drain", 8'h03 + 8'(i));
      end
      pulse_done(2);
      tick(6);
      chk("ovf_empty",    32'(cnt_a), 0);
      chk("ovf_no_extra", 32'(seen_a.size()), 0);
      chk("ovf_sticky",   32'(ovf_a), 1);

      // timeout: eight WAIT clocks, then next word issued
      do_reset();
      burst(8'hA0, 8'h01, 2);
      tick(8);
      chk("tmo_not_yet", 32'(to_a), 0);
      tick(1);
      chk("tmo_set",     32'(to_a), 1);
      chk("tmo_dv_low",  32'(dv_a), 0);
      tick(1);
      chk("tmo_next_dv",  32'(dv_a),  1);
      chk("tmo_next_txd", 32'(txd_a), 32'hA2);

      // gap: B reissues 7 clocks after the done clock, A after 2
      do_reset();
      burst(8'h50, 8'h10, 2);
      chk("gap_first_b", {23'h0, dv_b, txd_b}, {23'h0, 1'b1, 8'h55});
      tick(1);
      pulse_done(1);
      chk("gap_a_dv_low", 32'(dv_a), 0);
      tick(1);
      chk("gap_a_second", {23'h0, dv_a, txd_a}, {23'h0, 1'b1, 8'h61});
      tick(4);
      chk("gap_b_dv_low", 32'(dv_b), 0);
      tick(1);
      chk("gap_b_second", {23'h0, dv_b, txd_b}, {23'h0, 1'b1, 8'h65});

      // done during ISSUE is ignored: the FSM stays in WAIT
      do_reset();
      burst(8'h01, 8'h00, 1);
      tick(1);
      pulse_done(1);
      burst(8'h02, 8'h00, 1);
      tick(3);
      chk("issue_done_dv",  32'(dv_a),  0);
      chk("issue_done_cnt", 32'(cnt_a), 1);

      // reset mid-WAIT with 3 buffered words; late done produces nothing
      do_reset();
      burst(8'h70, 8'h01, 4);
      chk("rstmid_cnt3", 32'(cnt_a), 3);
      do_reset();
      chk("rstmid_dv",    32'(dv_a),  0);
      chk("rstmid_txd",   32'(txd_a), 0);
      chk("rstmid_cnt",   32'(cnt_a), 0);
      chk("rstmid_ovf",   32'(ovf_a), 0);
      chk("rstmid_to",    32'(to_a),  0);
      chk("rstmid_cnt_b", 32'(cnt_b), 0);
`ifdef TX_REPEATER_STATS_EN
      chk("rstmid_rxc", 32'(rxc_a), 0);
      chk("rstmid_txc", 32'(txc_a), 0);
`endif
      pulse_done(1);
      tick(5);
      chk("rstmid_no_issue", 32'(seen_a.size()), 0);
      chk("rstmid_dv_b",     32'(dv_b), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
